// File: rtl/xpmwrap_spram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// The read-tag id is sized for the largest supported requester count, so
// the struct stays a fixed-width package type that every arbiter can reuse.
package xpmwrap_spram_arb_pkg;

    localparam int unsigned MAX_REQ          = 16;
    localparam int unsigned DEF_READ_LATENCY = 2;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cycles from a granted read to its rsp_valid pulse.
    function automatic int unsigned rsp_lat(input int unsigned read_latency);
        return read_latency + 1;
    endfunction

    localparam int unsigned ID_W    = id_width(MAX_REQ);
    localparam int unsigned RSP_LAT = rsp_lat(DEF_READ_LATENCY);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/xpmwrap_spram_arb_if.sv
// Requester-side bus of the RAM arbiter: flattened request fields plus the
// shared read-response path. Optional macro: XPMWRAP_SPRAM_ARB_LOCK_EN adds req_lock.
interface xpmwrap_spram_arb_if #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_WIDTH_A = 6,
    parameter int unsigned DATA_WIDTH   = 32
) ();

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              req_we;
    logic [NUM_REQ*ADDR_WIDTH_A-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]           rsp_rdata;
`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]              req_lock;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lock,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lock,
        output req_ready, rsp_valid, rsp_rdata
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif

endinterface

// File: rtl/xpmwrap_rr_arb.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping. With XPMWRAP_SPRAM_ARB_LOCK_EN, lock restricts the grant to ptr only.
module xpmwrap_rr_arb
    import xpmwrap_spram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic hold;

`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    // Scan upward from the pointer; the first hit wins.
    always_comb begin
        int unsigned j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        if (hold) begin
            if (req[ptr]) begin
                gnt[ptr] = 1'b1;
                idx      = ptr;
                any      = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                j = (32'(ptr) + k) % NUM_REQ;
                if (!any && req[j]) begin
                    gnt[j] = 1'b1;
                    idx    = IDX_W'(j);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xpmwrap_spram_arb.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters.
// One access per cycle is registered onto the RAM port; read results are
// routed back by a tag pipeline matched to the RAM read latency.
// Optional macro: XPMWRAP_SPRAM_ARB_LOCK_EN (per-requester lock for exclusive access).
module xpmwrap_spram_arb
    import xpmwrap_spram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH_A   = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned READ_LATENCY_A = 2
) (
    input  logic                    clka,
    input  logic                    rsta_n,
    xpmwrap_spram_arb_if.slave      bus,
    output logic                    mem_ena,
    output logic                    mem_wea,
    output logic [ADDR_WIDTH_A-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0]   mem_dina,
    output logic                    mem_regcea,
    output logic                    mem_rsta,
    input  logic [DATA_WIDTH-1:0]   mem_douta
);

    localparam int unsigned IDX_W      = id_width(NUM_REQ);
    // The final latency stage is the rsp_valid register itself.
    localparam int unsigned TAG_STAGES = rsp_lat(READ_LATENCY_A) - 1;

    logic [NUM_REQ-1:0]      valid_eff;
    logic [NUM_REQ-1:0]      gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_any;
    logic [IDX_W-1:0]        ptr_q, ptr_d;

    logic                    mem_ena_q, mem_wea_q;
    logic [ADDR_WIDTH_A-1:0] mem_addra_q;
    logic [DATA_WIDTH-1:0]   mem_dina_q;

    rd_tag_t                 tag_in;
    rd_tag_t                 tag_q [TAG_STAGES];
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;

    // Nothing is granted while reset is held.
    assign valid_eff = bus.req_valid & {NUM_REQ{rsta_n}};

`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
    logic locked_q, locked_d;
    logic arb_lock;

    // Exclusive while the last locked winner keeps its lock high.
    assign arb_lock = locked_q & bus.req_lock[ptr_q];
`endif

    xpmwrap_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req  (valid_eff),
        .ptr  (ptr_q),
`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
        .lock (arb_lock),
`endif
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    // Pointer moves past the winner, or stays on a locking winner.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
            if (bus.req_lock[gnt_idx]) begin
                ptr_d = gnt_idx;
            end
`endif
        end
    end

`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
    // Lock is taken on a grant with lock high and released once lock drops.
    always_comb begin
        locked_d = locked_q;
        if (gnt_any) begin
            locked_d = bus.req_lock[gnt_idx];
        end else if (!arb_lock) begin
            locked_d = 1'b0;
        end
    end

    // Lock state register.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end
`endif

    // Pointer register.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Register the winning request onto the RAM port.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            mem_ena_q   <= 1'b0;
            mem_wea_q   <= 1'b0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
        end else begin
            mem_ena_q <= gnt_any;
            mem_wea_q <= gnt_any & bus.req_we[gnt_idx];
            if (gnt_any) begin
                mem_addra_q <= bus.req_addr[gnt_idx*ADDR_WIDTH_A +: ADDR_WIDTH_A];
                mem_dina_q  <= bus.req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Tag for the access being granted this cycle; writes carry no tag.
    always_comb begin
        tag_in.vld = gnt_any & ~bus.req_we[gnt_idx];
        tag_in.id  = ID_W'(gnt_idx);
    end

    // Decode the oldest tag into the one-hot response strobe.
    always_comb begin
        rsp_valid_d = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_valid_d[i] = tag_q[TAG_STAGES-1].vld && (tag_q[TAG_STAGES-1].id == ID_W'(i));
        end
    end

    // Tag shift register and response strobe register.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            for (int s = 0; s < int'(TAG_STAGES); s++) begin
                tag_q[s] <= '0;
            end
            rsp_valid_q <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int s = 1; s < int'(TAG_STAGES); s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = mem_douta;

    assign mem_ena    = mem_ena_q;
    assign mem_wea    = mem_wea_q;
    assign mem_addra  = mem_addra_q;
    assign mem_dina   = mem_dina_q;
    assign mem_regcea = 1'b1;
    assign mem_rsta   = ~rsta_n;

`ifndef SYNTHESIS
    rsp_onehot_a: assert property (@(posedge clka) disable iff (!rsta_n) $onehot0(rsp_valid_q));
`endif

endmodule

// File: tb/tb_xpmwrap_spram_arb.sv
// Bench for xpmwrap_spram_arb with a behavioural 2-cycle read_first RAM.
// Reads are scoreboarded at grant time and matched against rsp_valid/rsp_rdata.
module tb_xpmwrap_spram_arb;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clka = 1'b0;
    logic          rsta_n;
    logic          mem_ena, mem_wea, mem_regcea, mem_rsta;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_dina, mem_douta;

    xpmwrap_spram_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH_A(AW), .DATA_WIDTH(DW)) bus ();

    xpmwrap_spram_arb #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH_A   (AW),
        .DATA_WIDTH     (DW),
        .READ_LATENCY_A (2)
    ) dut (
        .clka       (clka),
        .rsta_n     (rsta_n),
        .bus        (bus),
        .mem_ena    (mem_ena),
        .mem_wea    (mem_wea),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_regcea (mem_regcea),
        .mem_rsta   (mem_rsta),
        .mem_douta  (mem_douta)
    );

    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    // RAM model: read_first, address sampled at one edge, data out after the next.
    logic [DW-1:0] ram [64];
    logic [DW-1:0] ram_s1;
    always @(posedge clka) begin
        if (mem_ena) begin
            if (mem_wea) ram[mem_addra] <= mem_dina;
            ram_s1 <= ram[mem_addra];
        end
        if (mem_rsta) mem_douta <= '0;
        else          mem_douta <= ram_s1;
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            id;
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb [$];
    exp_t          e;
    logic [DW-1:0] shadow [64];

    // Monitor: match due responses, flag stray ones, then log this cycle's transfer.
    always @(negedge clka) begin
        if (!rsta_n) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check_eq($sformatf("rsp_valid_r%0d", e.id), bus.rsp_valid, 64'(1) << e.id);
                check_eq($sformatf("rsp_rdata_r%0d", e.id), bus.rsp_rdata, e.data);
            end else if (bus.rsp_valid != '0) begin
                check_eq("rsp_spurious", bus.rsp_valid, 0);
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    if (bus.req_we[i]) begin
                        shadow[bus.req_addr[i*AW +: AW]] = bus.req_wdata[i*DW +: DW];
                    end else begin
                        sb.push_back('{id: i, due: cyc + 3,
                                       data: shadow[bus.req_addr[i*AW +: AW]]});
                    end
                end
            end
        end
    end

    task automatic set_req(input int id, input bit we, input int addr, input logic [DW-1:0] wd);
        bus.req_valid[id]            = 1'b1;
        bus.req_we[id]               = we;
        bus.req_addr[id*AW +: AW]    = AW'(addr);
        bus.req_wdata[id*DW +: DW]   = wd;
    endtask

    // Hold the request until granted (bounded), then drop valid after the edge.
    task automatic wait_gnt(input int id);
        int n;
        n = 0;
        @(negedge clka);
        while (!bus.req_ready[id] && n < 50) begin
            n++;
            @(negedge clka);
        end
        if (!bus.req_ready[id]) check_eq($sformatf("gnt_timeout_r%0d", id), 0, 1);
        @(posedge clka);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic do_write(input int id, input int addr, input logic [DW-1:0] wd);
        set_req(id, 1'b1, addr, wd);
        wait_gnt(id);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ready"},     bus.req_ready, 0);
        check_eq({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({pfx, "_mem_ena"},   mem_ena, 0);
        check_eq({pfx, "_mem_wea"},   mem_wea, 0);
        check_eq({pfx, "_mem_addra"}, mem_addra, 0);
        check_eq({pfx, "_mem_dina"},  mem_dina, 0);
        check_eq({pfx, "_mem_rsta"},  mem_rsta, 1);
        check_eq({pfx, "_regcea"},    mem_regcea, 1);
    endtask

    initial begin
        rsta_n        = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        repeat (2) @(negedge clka);
        check_reset_outputs("rst");
        @(posedge clka);
        #1;
        rsta_n = 1'b1;

        // Preload; ends with a grant to requester 3 so the pointer is back at 0.
        do_write(0, 5, 32'hDEAD_BEEF);
        for (int i = 0; i < NR; i++) do_write(i, i, {16'hC0DE, 16'(i)});

        // Single read by requester 2.
        set_req(2, 1'b0, 5, '0);
        @(negedge clka);
        check_eq("t1_ready", bus.req_ready, 4'b0100);
        @(posedge clka);
        #1;
        bus.req_valid[2] = 1'b0;
        @(negedge clka);
        check_eq("t1_mem_ena", mem_ena, 1);
        check_eq("t1_mem_wea", mem_wea, 0);
        check_eq("t1_mem_addra", mem_addra, 5);
        repeat (2) @(negedge clka);
        check_eq("t1_rsp_valid", bus.rsp_valid, 4'b0100);
        check_eq("t1_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

        // Pointer is at 3 now; one write by requester 3 returns it to 0.
        @(posedge clka);
        #1;
        do_write(3, 10, 32'h0BAD_F00D);

        // All four read continuously for 8 cycles.
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, '0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clka);
            check_eq($sformatf("t2_gnt%0d", k), bus.req_ready, 64'(1) << (k % NR));
        end
        @(posedge clka);
        #1;
        bus.req_valid = '0;

        // Write by requester 1 then read of the same address by requester 3.
        set_req(1, 1'b1, 63, 32'h1234_5678);
        set_req(3, 1'b0, 63, '0);
        @(negedge clka);
        check_eq("t3_ready_w", bus.req_ready, 4'b0010);
        @(posedge clka);
        #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clka);
        check_eq("t3_ready_r", bus.req_ready, 4'b1000);
        @(posedge clka);
        #1;
        bus.req_valid[3] = 1'b0;
        repeat (3) @(negedge clka);
        check_eq("t3_rsp_valid", bus.rsp_valid, 4'b1000);
        check_eq("t3_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);

        // Read by requester 0, then a reset pulse in the following cycle.
        @(posedge clka);
        #1;
        set_req(0, 1'b0, 5, '0);
        @(negedge clka);
        check_eq("t4_ready", bus.req_ready, 4'b0001);
        @(posedge clka);
        #1;
        bus.req_valid[0] = 1'b0;
        rsta_n           = 1'b0;
        @(negedge clka);
        check_reset_outputs("t4_rst");
        #1;
        rsta_n = 1'b1;
        @(posedge clka);
        #1;
        set_req(0, 1'b0, 5, '0);
        set_req(1, 1'b0, 0, '0);
        set_req(3, 1'b0, 3, '0);
        @(negedge clka);
        check_eq("t4_first_gnt", bus.req_ready, 4'b0001);
        @(posedge clka);
        #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clka);
        check_eq("t4_no_stale_rsp", bus.rsp_valid, 0);
        check_eq("t4_gnt_r1", bus.req_ready, 4'b0010);
        @(posedge clka);
        #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clka);
        check_eq("t4_gnt_r3", bus.req_ready, 4'b1000);
        @(posedge clka);
        #1;
        bus.req_valid[3] = 1'b0;

`ifdef XPMWRAP_SPRAM_ARB_LOCK_EN
        // Requester 1 locks for three reads while requester 2 waits.
        set_req(1, 1'b0, 63, '0);
        bus.req_lock[1] = 1'b1;
        set_req(2, 1'b0, 5, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clka);
            check_eq($sformatf("t5_lock_gnt%0d", k), bus.req_ready, 4'b0010);
        end
        @(posedge clka);
        #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clka);
        check_eq("t5_blocked", bus.req_ready, 0);
        @(posedge clka);
        #1;
        bus.req_lock[1] = 1'b0;
        @(negedge clka);
        check_eq("t5_release", bus.req_ready, 4'b0100);
        @(posedge clka);
        #1;
        bus.req_valid[2] = 1'b0;
`endif

        // Let outstanding responses drain.
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clka);
        check_eq("sb_drain", sb.size(), 0);
        repeat (2) @(negedge clka);
        check_eq("idle_rsp_valid", bus.rsp_valid, 0);
        check_eq("idle_mem_ena", mem_ena, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
